ext_arbiter: RTL and testbench
==============================

# ext_arbiter

Two-port arbiter that shares one immediate-extension unit between two requesters in the decode stage of the pipelined 16-bit processor. Each requester submits an 11-bit raw immediate and an extension mode; the block grants one request per cycle, round-robin, and returns the extended 16-bit value through a one-entry output register with a valid/ready handshake. Illegal modes are flagged on `err`. A `flush` input discards in-flight results on pipeline redirects.

## Interface
Parameters:
- `W_IMM`, 11, raw immediate width
- `W_OUT`, 16, extended data width

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req0`, `req1`  in  1  request; held high until the matching grant
- `mode0`, `mode1`  in  3  extension mode; stable while the request is pending
- `imm0`, `imm1`  in  `W_IMM`  raw immediate; low bits are used per mode
- `gnt0`, `gnt1`  out  1  one-cycle grant pulse, combinational
- `flush`  in  1  discard output register contents; no grant this cycle
- `out_valid`  out  1  output register holds a result
- `out_ready`  in  1  consumer accepts the result when high together with `out_valid`
- `out_data`  out  `W_OUT`  extended immediate
- `out_src`  out  1  requester index of `out_data`
- `err`  out  1  qualified by `out_valid`; the result came from an illegal mode

## Operation
- Modes:
  - 000: zero-extend `imm[4:0]`
  - 001: sign-extend `imm[4:0]`
  - 010: zero-extend `imm[7:0]`
  - 011: sign-extend `imm[7:0]`
  - 100: sign-extend `imm[10:0]`
  - 101: zero-extend `imm[10:0]`
  - 110, 111: illegal. The request is still granted and delivered, with `out_data` = 0 and `err` = 1.
- Slot free condition: `!out_valid || (out_valid && out_ready)`.
- Grant rule: a grant is issued only when the slot is free and `flush` is 0.
  - One requester active: that requester is granted.
  - Both active: the requester other than `last` is granted.
- `last` pointer:
  - Updated to the granted index on every grant.
  - Unchanged when there is no grant.
  - Unchanged by `flush`.
- Fairness: a pending requester is granted within 2 grant opportunities.
- On grant: `out_data`, `out_src`, `err` and `out_valid` are loaded on the next edge.
- Drain with no new grant: `out_valid` clears.
- `flush` takes priority over all else:
  - `out_valid` goes to 0 on the next edge.
  - Grants are forced low that cycle.
  - A result being drained in the same cycle counts as delivered to the consumer; that is the consumer's responsibility.
- Reset values:
  - `out_valid`, `err`, `out_src` = 0
  - `out_data` = 0x0000
  - `last` = 1, so `req0` wins the first tie
  - `gnt0`, `gnt1` = 0 while `rst` is low
- Reset asserted mid-operation: all registered state returns to reset values immediately (asynchronous). A pending request must be re-granted after release.

## Timing
- Latency: grant cycle N gives `out_valid` in cycle N+1. At full throughput, with `out_ready` held high, one result per cycle.
- Back-to-back: a grant can occur in the same cycle the current result drains.
- Stall: while `out_valid && !out_ready`:
  - `out_data`, `out_src` and `err` hold.
  - No grants are issued.
- Grants are combinational from `req*`, `out_valid`, `out_ready`, `flush` and `last`. There is no combinational path from `mode`/`imm` to `gnt`.
- `gnt0` and `gnt1` are never high in the same cycle.

## Structure
- Shared header `ext_defs.vh`:
  - mode encodings `EXT_ZE5`, `EXT_SE5`, `EXT_ZE8`, `EXT_SE8`, `EXT_SE11`, `EXT_ZE11`
  - widths `W_IMM`, `W_OUT`
- Sub-module `ext_core`: combinational (mode, imm) → (data, illegal). Instantiated once, fed by the granted requester's mux output.
- The top level holds the arbiter logic, the `last` pointer and the output register.

## Test plan
- Single requester: `req0`, mode 011, imm 0x0F0, `out_ready` = 1 → `gnt0` in cycle N; `out_data` = 0xFFF0, `out_src` = 0, `err` = 0 in cycle N+1.
- Mode sweep on `req1`, one per cycle:
  - 000 / 0x01F → 0x001F
  - 001 / 0x010 → 0xFFF0
  - 010 / 0x0FF → 0x00FF
  - 100 / 0x400 → 0xFC00
  - 101 / 0x400 → 0x0400
  - 110 → 0x0000 with `err` = 1
- Both requesters held continuously after reset, `out_ready` = 1 → grants alternate 0, 1, 0, 1; `out_src` follows one cycle later; 1 result per cycle.
- Backpressure: result valid, `out_ready` = 0 for 3 cycles with `req1` pending → no grant; output held stable. On the cycle `out_ready` rises, `gnt1` fires and the new result appears on the next cycle.
- `flush` asserted while `out_valid` = 1 and `req0` pending → `gnt0` = 0 that cycle; `out_valid` = 0 next cycle; `gnt0` the cycle after `flush` drops.
- `rst` pulsed low with `out_valid` = 1 and `last` = 0 → outputs return to 0 asynchronously. After release, with both requesting, `gnt0` is granted first.

Source files
------------

// File: rtl/ext_arbiter_pkg.sv
// Shared definitions for the decode-stage immediate extension arbiter:
// default widths and the extension mode encodings.
package ext_arbiter_pkg;

  localparam int EXT_W_IMM = 11;
  localparam int EXT_W_OUT = 16;

  typedef enum logic [2:0] {
    EXT_ZE5  = 3'b000,
    EXT_SE5  = 3'b001,
    EXT_ZE8  = 3'b010,
    EXT_SE8  = 3'b011,
    EXT_SE11 = 3'b100,
    EXT_ZE11 = 3'b101
  } ext_mode_e;

endpackage

// File: rtl/ext_arbiter_core.sv
// Combinational immediate extension unit shared by both requesters.
// Codes 110/111 yield zero data with illegal_o raised.
module ext_core
  import ext_arbiter_pkg::*;
#(
  parameter int W_IMM = EXT_W_IMM,
  parameter int W_OUT = EXT_W_OUT
) (
  input  logic [2:0]       mode_i,
  input  logic [W_IMM-1:0] imm_i,
  output logic [W_OUT-1:0] data_o,
  output logic             illegal_o
);

  always_comb begin
    data_o    = '0;
    illegal_o = 1'b0;
    case (mode_i)
      EXT_ZE5:  data_o = {{(W_OUT-5){1'b0}}, imm_i[4:0]};
      EXT_SE5:  data_o = {{(W_OUT-5){imm_i[4]}}, imm_i[4:0]};
      EXT_ZE8:  data_o = {{(W_OUT-8){1'b0}}, imm_i[7:0]};
      EXT_SE8:  data_o = {{(W_OUT-8){imm_i[7]}}, imm_i[7:0]};
      EXT_SE11: data_o = {{(W_OUT-11){imm_i[10]}}, imm_i[10:0]};
      EXT_ZE11: data_o = {{(W_OUT-11){1'b0}}, imm_i[10:0]};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/ext_arbiter.sv
// Round-robin arbiter sharing one ext_core between two decode requesters,
// with a one-entry valid/ready output register and a flush for redirects.
module ext_arbiter
  import ext_arbiter_pkg::*;
#(
  parameter int W_IMM = EXT_W_IMM,
  parameter int W_OUT = EXT_W_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [2:0]       mode0,
  input  logic [2:0]       mode1,
  input  logic [W_IMM-1:0] imm0,
  input  logic [W_IMM-1:0] imm1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OUT-1:0] out_data,
  output logic             out_src,
  output logic             err
);

  // Handshake: a result transfers on a rising edge where out_valid and
  // out_ready are both high; the slot may be refilled in that same cycle.
  logic             out_valid_q, out_valid_d;
  logic [W_OUT-1:0] out_data_q, out_data_d;
  logic             out_src_q, out_src_d;
  logic             err_q, err_d;
  logic             last_q, last_d;

  logic             slot_free;
  logic             grant_ok;
  logic             gnt0_c, gnt1_c;
  logic [2:0]       sel_mode;
  logic [W_IMM-1:0] sel_imm;
  logic [W_OUT-1:0] core_data;
  logic             core_illegal;

  assign slot_free = !out_valid_q || out_ready;
  // rst gates grants so nothing is issued while the block is held in reset.
  assign grant_ok  = rst && slot_free && !flush;
  assign gnt0_c    = grant_ok && req0 && (!req1 || last_q);
  assign gnt1_c    = grant_ok && req1 && (!req0 || !last_q);

  assign gnt0 = gnt0_c;
  assign gnt1 = gnt1_c;

  assign sel_mode = gnt1_c ? mode1 : mode0;
  assign sel_imm  = gnt1_c ? imm1  : imm0;

  ext_core #(
    .W_IMM (W_IMM),
    .W_OUT (W_OUT)
  ) u_core (
    .mode_i    (sel_mode),
    .imm_i     (sel_imm),
    .data_o    (core_data),
    .illegal_o (core_illegal)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    err_d       = err_q;
    last_d      = last_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (gnt0_c || gnt1_c) begin
      out_valid_d = 1'b1;
      out_data_d  = core_data;
      out_src_d   = gnt1_c;
      err_d       = core_illegal;
      last_d      = gnt1_c;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      err_q       <= err_d;
      last_q      <= last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ext_arbiter.sv
// Bench for ext_arbiter: directed scenarios plus random traffic, checked by
// a reference model feeding an expected-result queue and a delivery monitor.
module tb_ext_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [2:0]  mode0, mode1;
  logic [10:0] imm0, imm1;
  logic        gnt0, gnt1;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_src;
  logic        err;

  ext_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .req1      (req1),
    .mode0     (mode0),
    .mode1     (mode1),
    .imm0      (imm0),
    .imm1      (imm1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .err       (err)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [17:0] exp_q[$];          // {src, err, data}
  bit          mdl_on   = 0;
  bit          mdl_occ  = 0;      // model: output register holds a result
  bit          mdl_last = 1;
  bit          g0_seen  = 0;
  bit          g1_seen  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Extension by arithmetic on the field value, not by bit replication.
  function automatic logic [17:0] ref_ext(input bit src, input logic [2:0] m, input logic [10:0] imm);
    int n;
    bit sgn;
    int v;
    case (m)
      3'd0: begin n = 5;  sgn = 0; end
      3'd1: begin n = 5;  sgn = 1; end
      3'd2: begin n = 8;  sgn = 0; end
      3'd3: begin n = 8;  sgn = 1; end
      3'd4: begin n = 11; sgn = 1; end
      3'd5: begin n = 11; sgn = 0; end
      default: return {src, 1'b1, 16'h0000};
    endcase
    v = int'(imm) % (1 << n);
    if (sgn && v >= (1 << (n - 1))) v = v - (1 << n);
    return {src, 1'b0, 16'(v)};
  endfunction

  // ---------------- reference model: grants and expected results ----------------
  always @(negedge clk) begin
    bit free, ok, e0, e1;
    #1;
    if (mdl_on) begin
      e0 = 0;
      e1 = 0;
      if (!rst) begin
        exp_q.delete();
        mdl_occ  = 0;
        mdl_last = 1;
      end else begin
        free = !mdl_occ || out_ready;
        ok   = free && !flush;
        if (ok && req0 && req1) begin
          e0 = mdl_last;
          e1 = !mdl_last;
        end else if (ok) begin
          e0 = req0;
          e1 = req1;
        end
        if (flush) begin
          exp_q.delete();
          mdl_occ = 0;
        end else if (e0 || e1) begin
          exp_q.push_back(e1 ? ref_ext(1'b1, mode1, imm1) : ref_ext(1'b0, mode0, imm0));
          mdl_occ  = 1;
          mdl_last = e1;
        end else if (out_ready) begin
          mdl_occ = 0;
        end
      end
      chk("gnt0", gnt0, e0);
      chk("gnt1", gnt1, e1);
      g0_seen = e0;
      g1_seen = e1;
    end
  end

  // ---------------- monitor: delivery and stall hold ----------------
  bit          stall_prev = 0;
  logic [17:0] held_prev;

  always @(negedge clk) begin
    logic [17:0] e;
    if (mdl_on && rst) begin
      chk("out_valid", out_valid, mdl_occ);
      if (out_valid && stall_prev) chk("stall_hold", {out_src, err, out_data}, held_prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {out_src, err, out_data}, e);
        end
      end
      stall_prev = out_valid && !out_ready && !flush;
      held_prev  = {out_src, err, out_data};
    end else begin
      stall_prev = 0;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_occ  = 0;
    mdl_last = 1;
    g0_seen  = 0;
    g1_seen  = 0;
  endtask

  initial begin
    logic [2:0]  sw_m [6];
    logic [10:0] sw_i [6];
    sw_m = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
    sw_i = '{11'h01F, 11'h010, 11'h0FF, 11'h400, 11'h400, 11'h000};

    rst = 0; req0 = 0; req1 = 0; mode0 = 0; mode1 = 0;
    imm0 = 0; imm1 = 0; flush = 0; out_ready = 1;

    // Reset state, with a request present to prove grants stay low.
    tick();
    req0 = 1;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_src", out_src, 0);
    chk("rst_err", err, 0);
    req0 = 0;
    tick();
    rst = 1;
    mdl_on = 1;

    // Single requester: SE8 of 0x0F0.
    tick();
    req0 = 1; mode0 = 3'd3; imm0 = 11'h0F0; out_ready = 1;
    tick();
    req0 = 0;
    @(negedge clk);
    #2;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 16'hFFF0);
    chk("single_src", out_src, 0);
    chk("single_err", err, 0);

    // Mode sweep on req1, one per cycle.
    tick();
    for (int i = 0; i < 6; i++) begin
      req1 = 1; mode1 = sw_m[i]; imm1 = sw_i[i];
      tick();
    end
    req1 = 0;
    repeat (2) tick();

    // Both held after a fresh reset: grants alternate starting with 0.
    rst = 0;
    model_reset();
    tick();
    rst = 1;
    req0 = 1; req1 = 1; mode0 = 3'd5; mode1 = 3'd4;
    imm0 = 11'($urandom); imm1 = 11'($urandom);
    @(negedge clk);
    #2;
    chk("alt_first_gnt0", gnt0, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (g0_seen) imm0 = 11'($urandom);
      if (g1_seen) imm1 = 11'($urandom);
    end
    req0 = 0; req1 = 0;
    tick();

    // Backpressure: stall 3 cycles with req1 pending, then release.
    req0 = 1; mode0 = 3'd2; imm0 = 11'h0A5; out_ready = 0;
    tick();
    req0 = 0; req1 = 1; mode1 = 3'd1; imm1 = 11'h00C;
    repeat (3) tick();
    out_ready = 1;
    tick();
    req1 = 0;
    repeat (2) tick();

    // Flush with a valid result and req0 pending.
    req1 = 1; mode1 = 3'd0; imm1 = 11'h013; out_ready = 0;
    tick();
    req1 = 0; req0 = 1; mode0 = 3'd3; imm0 = 11'h07F; flush = 1;
    tick();
    flush = 0;
    tick();
    req0 = 0; out_ready = 1;
    repeat (2) tick();

    // Asynchronous reset with out_valid=1 and last=0, both then requesting.
    req0 = 1; mode0 = 3'd3; imm0 = 11'h0F0; out_ready = 0;
    tick();
    req0 = 1; req1 = 1; mode1 = 3'd2; imm1 = 11'h055;
    @(posedge clk);
    #3;
    rst = 0;
    model_reset();
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 16'h0000);
    chk("arst_src", out_src, 0);
    chk("arst_err", err, 0);
    chk("arst_gnt0", gnt0, 0);
    chk("arst_gnt1", gnt1, 0);
    tick();
    rst = 1; out_ready = 1;
    @(negedge clk);
    #2;
    chk("post_rst_gnt0", gnt0, 1);
    chk("post_rst_gnt1", gnt1, 0);
    tick();
    if (g0_seen) req0 = 0;
    tick();
    if (g1_seen) req1 = 0;
    req0 = 0;
    tick();
    req1 = 0;
    repeat (2) tick();

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      if (!req0 || g0_seen) begin
        req0  = ($urandom_range(0, 2) != 0);
        mode0 = 3'($urandom_range(0, 7));
        imm0  = 11'($urandom);
      end
      if (!req1 || g1_seen) begin
        req1  = ($urandom_range(0, 2) != 0);
        mode1 = 3'($urandom_range(0, 7));
        imm1  = 11'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    // Drain and confirm nothing is left outstanding.
    req0 = 0; req1 = 0; flush = 0; out_ready = 1;
    repeat (3) tick();
    chk("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
